histogram_ram_arbiter: RTL and testbench
========================================

// Module: histogram_ram_arbiter
// PURPOSE
//  Owns the single-port histogram RAM that the correlation-bin distributer feeds.
//  Turns each Memory_add pulse plus its Addr into a saturating read-modify-write increment.
//  Shares the same RAM with the host readout path and a full-memory clear sweep.
//  Sits between plot_distributer (upstream) and the block RAM and host/UART readout (downstream).
// PARAMETERS
//  ADDR_W      7   histogram address width; the RAM holds 2**ADDR_W bins
//  DATA_W      32  bin counter width
//  FIFO_DEPTH  4   pending-increment queue depth (power of 2, >=2)
// PORTS
//  clk        in   1       system clock, single clock domain
//  rst        in   1       synchronous, active-high reset
//  inc_req    in   1       Memory_add level from the distributer; its rising edge = one event
//  inc_addr   in   ADDR_W  bin address, sampled on the inc_req rising edge
//  clr_req    in   1       one-cycle pulse: zero every bin
//  rd_req     in   1       host read request, accepted only when rd_ready=1
//  rd_addr    in   ADDR_W  host read address, sampled on acceptance
//  rd_ready   out  1       high in IDLE when no clear is pending
//  rd_valid   out  1       one-cycle strobe: rd_data is valid
//  rd_data    out  DATA_W  bin value returned to the host
//  ram_addr   out  ADDR_W  RAM address
//  ram_we     out  1       RAM write enable
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data; 1-cycle read latency
//  busy       out  1       high whenever the FSM is not in IDLE
//  ovf        out  1       sticky flag: an increment was dropped; cleared by rst or by a clear
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty; all outputs 0 except rd_ready=1. RAM contents are not touched.
//  Edge detect: inc_req is registered; a 0->1 transition pushes inc_addr into the FIFO.
//   - A level held for several cycles (the distributer's 6-cycle pulse) counts as one event.
//  FIFO full at push time: the event is dropped and ovf is set.
//   - Exception: if a pop happens in the same cycle, the push is accepted.
//  FSM states: IDLE, CLR, INC_RD, INC_WAIT, INC_WR, HRD, HRD_WAIT.
//  IDLE arbitration, fixed priority: clear pending > FIFO not empty > rd_req.
//  CLR: ram_we=1, wdata=0, sweeps addr 0..2**ADDR_W-1 one address per cycle.
//   - Returns to IDLE after the last address; ovf is cleared at sweep end.
//   - Events arriving during CLR are queued in the FIFO, never lost unless the FIFO is full.
//  Increment: INC_RD pops the FIFO and drives ram_addr; INC_WAIT waits for read data.
//   - INC_WR writes ram_rdata+1, saturating at all-ones.
//   - Throughput: 3 cycles per increment plus 1 cycle back in IDLE (4 cycles per event).
//   - Increments are strictly serial, so back-to-back events to the same bin need no forwarding.
//  Host read: HRD drives rd_addr; HRD_WAIT captures ram_rdata.
//   - rd_valid pulses on the cycle after HRD_WAIT, i.e. 3 cycles after acceptance.
//  clr_req during any state: latched as pending.
//   - The current operation completes first; an RMW is never split.
//   - clr_req during CLR restarts nothing; the pulse is absorbed.
//  rd_req while rd_ready=0: ignored; the host must hold or retry.
//  rst mid-operation: abort immediately to the reset state. A partially done RMW is
//   discarded, i.e. the bin is not incremented.
//  ram_we is high only in INC_WR and CLR.
// STRUCTURE
//  hist_pkg: fsm state enum and default ADDR_W/DATA_W localparams.
//  Sub-module hist_inc_fifo: sync FIFO with push/pop/full/empty, depth FIFO_DEPTH.
//   - Carries the drop/overflow indication to the top level.
//  Top level: edge detector, arbiter FSM, saturating adder, clear address counter.
// TESTING
//  - Single inc_req pulse (6 cycles high) with addr=64, RAM bin=5 -> exactly one write of 6 to addr 64.
//  - Three events to addr 70 spaced 2 cycles apart -> all queued; bin ends at +3 with no ovf.
//  - 6 rapid events with FIFO_DEPTH=4 -> 4 or 5 land (per pop timing); ovf=1; bin count matches.
//  - Bin preloaded 0xFFFFFFFF, one event -> bin stays 0xFFFFFFFF.
//  - clr_req mid-increment -> RMW completes, then 128 zero writes; ovf=0; queued event lands after.
//  - rd_req addr=64 after 2 increments from 0 -> rd_valid 3 cycles later with rd_data=2.
//  - rst asserted in INC_WAIT -> no write occurs; FIFO empty; rd_ready=1 next cycle.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and default widths for the histogram RAM arbiter.
package hist_pkg;

    localparam int unsigned HIST_ADDR_W = 7;
    localparam int unsigned HIST_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StIncRd,
        StIncWait,
        StIncWr,
        StHrd,
        StHrdWait
    } hist_state_e;

endpackage

// File: rtl/hist_inc_fifo.sv
// Pending-increment address queue; reports pushes that had to be dropped.
module hist_inc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full queue still fits.
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign drop     = push & full & ~pop;
    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/histogram_ram_arbiter.sv
// Single-port histogram RAM owner: serial saturating increments, host readout and clear sweep.
module histogram_ram_arbiter
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W     = HIST_ADDR_W,
    parameter int unsigned DATA_W     = HIST_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_req,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              clr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              ovf
);

    hist_state_e       state_q, state_d;
    logic              inc_q;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] inc_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              ovf_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [ADDR_W-1:0] fifo_data;
    logic              rd_accept, clr_start, sweep_end;
    logic [DATA_W-1:0] sat_inc;

    assign fifo_push = inc_req & ~inc_q;

    hist_inc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (inc_addr),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign sat_inc   = (&ram_rdata) ? ram_rdata : ram_rdata + 1'b1;
    assign rd_ready  = (state_q == StIdle) & ~clr_pend_q;
    assign busy      = (state_q != StIdle);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ovf       = ovf_q;
    assign clr_start = (state_q == StIdle) & clr_pend_q;
    assign sweep_end = (state_q == StClr) & (&clr_cnt_q);

    // A clear request during a sweep is absorbed rather than queued for a second sweep.
    assign clr_pend_d = clr_start ? 1'b0 : (clr_pend_q | (clr_req & (state_q != StClr)));

    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        fifo_pop  = 1'b0;
        rd_accept = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_pend_q) begin
                    state_d = StClr;
                end else if (!fifo_empty) begin
                    state_d = StIncRd;
                end else if (rd_req) begin
                    rd_accept = 1'b1;
                    state_d   = StHrd;
                end
            end
            StClr: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
                if (&clr_cnt_q) state_d = StIdle;
            end
            StIncRd: begin
                fifo_pop = 1'b1;
                ram_addr = fifo_data;
                state_d  = StIncWait;
            end
            // Address is held so the RAM output still reflects the bin during the write.
            StIncWait: begin
                ram_addr = inc_addr_q;
                state_d  = StIncWr;
            end
            StIncWr: begin
                ram_addr  = inc_addr_q;
                ram_we    = 1'b1;
                ram_wdata = sat_inc;
                state_d   = StIdle;
            end
            StHrd: begin
                ram_addr = rd_addr_q;
                state_d  = StHrdWait;
            end
            StHrdWait: begin
                ram_addr = rd_addr_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            inc_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
            inc_addr_q <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inc_q      <= inc_req;
            clr_pend_q <= clr_pend_d;
            rd_valid_q <= (state_q == StHrdWait);
            if (state_q == StClr) clr_cnt_q <= clr_cnt_q + 1'b1;
            if (fifo_pop)         inc_addr_q <= fifo_data;
            if (rd_accept)        rd_addr_q <= rd_addr;
            if (state_q == StHrdWait) rd_data_q <= ram_rdata;
            // A drop in the sweep's final cycle still leaves the flag set.
            if (fifo_drop)      ovf_q <= 1'b1;
            else if (sweep_end) ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_histogram_ram_arbiter.sv
// Directed bench for histogram_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_histogram_ram_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inc_req;
    logic [AW-1:0] inc_addr;
    logic          clr_req;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;
    logic          ovf;

    logic [DW-1:0] mem [2**AW];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    int wr0;

    always #5 clk = ~clk;

    histogram_ram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inc_req   (inc_req),
        .inc_addr  (inc_addr),
        .clr_req   (clr_req),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .ovf       (ovf)
    );

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_wr_addr  <= ram_addr;
            last_wr_data  <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick(1);
        pl_en = 1'b0;
    endtask

    task automatic pulse(input logic [AW-1:0] a);
        inc_addr = a; inc_req = 1'b1;
        tick(1);
        inc_req = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; inc_req = 1'b0; inc_addr = '0; clr_req = 1'b0;
        rd_req = 1'b0; rd_addr = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        tick(2);
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick(1);

        // 6-cycle level counts as one event
        preload(7'd64, 32'd5);
        wr0 = wr_cnt;
        inc_addr = 7'd64; inc_req = 1'b1;
        tick(6);
        inc_req = 1'b0;
        tick(12);
        chk("single_wr_cnt", 64'(wr_cnt - wr0), 64'd1);
        chk("single_wr_addr", 64'(last_wr_addr), 64'd64);
        chk("single_wr_data", 64'(last_wr_data), 64'd6);
        chk("single_bin", 64'(mem[64]), 64'd6);

        // three queued events to one bin
        preload(7'd70, 32'd10);
        wr0 = wr_cnt;
        pulse(7'd70); pulse(7'd70); pulse(7'd70);
        tick(16);
        chk("triple_bin", 64'(mem[70]), 64'd13);
        chk("triple_wr_cnt", 64'(wr_cnt - wr0), 64'd3);
        chk("triple_ovf", 64'(ovf), 64'd0);

        // Fill the queue during a sweep so events right after it overflow
        preload(7'd80, 32'd7);
        wr0 = wr_cnt;
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        chk("clr_pend_rd_ready", 64'(rd_ready), 64'd0);
        tick(1);
        chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_we", 64'(ram_we), 64'd1);
        chk("clr_first_addr", 64'(ram_addr), 64'd0);
        chk("clr_wdata", 64'(ram_wdata), 64'd0);
        tick(120);
        for (int i = 0; i < 6; i++) pulse(7'd80);
        chk("burst_ovf_set", 64'(ovf), 64'd1);
        tick(40);
        chk("burst_bin", 64'(mem[80]), 64'd5);
        chk("burst_wr_cnt", 64'(wr_cnt - wr0), 64'd133);
        chk("burst_cleared_64", 64'(mem[64]), 64'd0);
        chk("burst_cleared_70", 64'(mem[70]), 64'd0);
        chk("burst_ovf_sticky", 64'(ovf), 64'd1);

        // saturation
        preload(7'd90, 32'hFFFF_FFFF);
        wr0 = wr_cnt;
        pulse(7'd90);
        tick(10);
        chk("sat_bin", 64'(mem[90]), 64'hFFFF_FFFF);
        chk("sat_wr_data", 64'(last_wr_data), 64'hFFFF_FFFF);
        chk("sat_wr_cnt", 64'(wr_cnt - wr0), 64'd1);

        // clear arriving during INC_WAIT; second event queued behind the sweep
        preload(7'd100, 32'd3);
        preload(7'd101, 32'd50);
        wr0 = wr_cnt;
        inc_addr = 7'd100; inc_req = 1'b1;
        tick(1);
        inc_req = 1'b0;
        tick(1);
        inc_addr = 7'd101; inc_req = 1'b1;
        tick(1);
        inc_req = 1'b0; clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        tick(150);
        chk("midclr_wr_cnt", 64'(wr_cnt - wr0), 64'd130);
        chk("midclr_bin100", 64'(mem[100]), 64'd0);
        chk("midclr_bin101", 64'(mem[101]), 64'd1);
        chk("midclr_ovf", 64'(ovf), 64'd0);

        // host read after two increments from zero
        pulse(7'd64);
        pulse(7'd64);
        tick(12);
        rd_addr = 7'd64; rd_req = 1'b1;
        chk("hrd_ready", 64'(rd_ready), 64'd1);
        tick(1);
        rd_req = 1'b0;
        chk("hrd_busy", 64'(busy), 64'd1);
        chk("hrd_ready_low", 64'(rd_ready), 64'd0);
        chk("hrd_valid_c1", 64'(rd_valid), 64'd0);
        tick(1);
        chk("hrd_valid_c2", 64'(rd_valid), 64'd0);
        tick(1);
        chk("hrd_valid_c3", 64'(rd_valid), 64'd1);
        chk("hrd_data", 64'(rd_data), 64'd2);
        tick(1);
        chk("hrd_valid_end", 64'(rd_valid), 64'd0);

        // reset during INC_WAIT discards the RMW and the queue
        preload(7'd110, 32'd9);
        preload(7'd111, 32'd4);
        wr0 = wr_cnt;
        inc_addr = 7'd110; inc_req = 1'b1;
        tick(1);
        inc_req = 1'b0;
        tick(1);
        inc_addr = 7'd111; inc_req = 1'b1;
        tick(1);
        inc_req = 1'b0; rst = 1'b1;
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        tick(1);
        rst = 1'b0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_rd_ready", 64'(rd_ready), 64'd1);
        chk("rstmid_we", 64'(ram_we), 64'd0);
        tick(8);
        chk("rstmid_idle", 64'(busy), 64'd0);
        chk("rstmid_wr_cnt", 64'(wr_cnt - wr0), 64'd0);
        chk("rstmid_bin110", 64'(mem[110]), 64'd9);
        chk("rstmid_bin111", 64'(mem[111]), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
